top_level_proc: RTL and testbench

- Self-contained pattern-count engine for program 3: searches a 256-bit message held in internal data memory for a 5-bit pattern.
- Writes three counts back to memory, then raises done.
- Sits at the top of the program-3 design. Memory is preloaded hierarchically by the bench or loader; start is pulsed; results are read back from memory.

---
 rtl/top_level_proc.sv | 168 ++++++++++++++++
 tb/tb_top_level_proc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_level_proc.sv
// Program-3 pattern-count engine: counts 5-bit pattern hits in a 32-byte message held in dm1.
// Optional MEM_LOAD_PORT_EN adds a byte-wide load port usable while idle or done.
module top_level_proc_dm #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] core [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) core[waddr] <= wdata;
    end

    assign rdata = core[raddr];
endmodule

module top_level_proc #(
    parameter int MSG_BYTES = 32,
    parameter int PAT_ADDR  = 32,
    parameter int MEM_DEPTH = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef MEM_LOAD_PORT_EN
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_data,
`endif
    output logic       done
);
    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_PAT, S_SCAN, S_WR33, S_WR34, S_WR35, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [4:0]    pat_q, pat_d;
    logic [3:0]    prev_q, prev_d;
    logic [7:0]    ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
    logic          done_q, done_d;

    logic          mem_we;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [7:0]    mem_wdata, rd_data;

    top_level_proc_dm #(.DEPTH(MEM_DEPTH), .AW(AW)) dm1 (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (rd_data)
    );

    // Low nibble of the previous byte followed by the current byte: the crossing windows live here.
    logic [11:0] win;
    logic [3:0]  in_hit, x_hit;
    assign win = {prev_q, rd_data};

    for (genvar gi = 0; gi < 4; gi++) begin : g_match
        assign in_hit[gi] = (rd_data[gi+4:gi] == pat_q);
        assign x_hit[gi]  = (win[gi+8:gi+4] == pat_q);
    end

    function automatic logic [7:0] pop4(input logic [3:0] v);
        return {7'd0, v[0]} + {7'd0, v[1]} + {7'd0, v[2]} + {7'd0, v[3]};
    endfunction

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        pat_d     = pat_q;
        prev_d    = prev_q;
        ctb_d     = ctb_q;
        cto_d     = cto_q;
        cts_d     = cts_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_raddr = i_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_PAT;
`ifdef MEM_LOAD_PORT_EN
                if (ld_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = AW'(ld_addr);
                    mem_wdata = ld_data;
                end
`endif
            end
            S_PAT: begin
                mem_raddr = AW'(PAT_ADDR);
                pat_d     = rd_data[7:3];
                ctb_d     = '0;
                cto_d     = '0;
                cts_d     = '0;
                prev_d    = '0;
                i_d       = '0;
                state_d   = S_SCAN;
            end
            S_SCAN: begin
                ctb_d  = ctb_q + pop4(in_hit);
                cto_d  = cto_q + {7'd0, |in_hit};
                // Byte 0 has no predecessor, so it contributes no crossing windows.
                cts_d  = cts_q + pop4(in_hit) + ((i_q != '0) ? pop4(x_hit) : 8'd0);
                prev_d = rd_data[3:0];
                i_d    = i_q + 1'b1;
                if (i_q == AW'(MSG_BYTES - 1)) state_d = S_WR33;
            end
            S_WR33: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(PAT_ADDR + 1);
                mem_wdata = ctb_q;
                state_d   = S_WR34;
            end
            S_WR34: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(PAT_ADDR + 2);
                mem_wdata = cto_q;
                state_d   = S_WR35;
            end
            S_WR35: begin
                mem_we    = 1'b1;
                mem_waddr = AW'(PAT_ADDR + 3);
                mem_wdata = cts_q;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            pat_q   <= '0;
            prev_q  <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            pat_q   <= pat_d;
            prev_q  <= prev_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
endmodule

// File: tb/tb_top_level_proc.sv
// Directed and model-checked bench for the program-3 pattern-count engine.
module tb_top_level_proc;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic done;
`ifdef MEM_LOAD_PORT_EN
    logic       ld_we = 1'b0;
    logic [7:0] ld_addr = 8'd0;
    logic [7:0] ld_data = 8'd0;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] msg [0:31];
    logic [7:0] patbyte;

    top_level_proc dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef MEM_LOAD_PORT_EN
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
`endif
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_mem();
        for (int i = 0; i < 32; i++) dut.dm1.core[i] = msg[i];
        dut.dm1.core[32] = patbyte;
    endtask

    task automatic fill(input logic [7:0] b, input logic [7:0] p);
        for (int i = 0; i < 32; i++) msg[i] = b;
        patbyte = p;
        load_mem();
    endtask

    // Bit-level reference over the 256-bit stream S.
    task automatic ref_model(output logic [7:0] e_ctb, output logic [7:0] e_cto, output logic [7:0] e_cts);
        logic [255:0] s;
        logic [4:0]   pat;
        int           ctb, cto, cts;
        bit           hit;
        pat = patbyte[7:3];
        ctb = 0; cto = 0; cts = 0;
        for (int i = 0; i < 32; i++) begin
            s[255-8*i -: 8] = msg[i];
            hit = 0;
            for (int k = 0; k < 4; k++) begin
                if (msg[i][k +: 5] == pat) begin
                    ctb++;
                    hit = 1;
                end
            end
            if (hit) cto++;
        end
        for (int j = 0; j < 252; j++) if (s[255-j -: 5] == pat) cts++;
        e_ctb = 8'(ctb); e_cto = 8'(cto); e_cts = 8'(cts);
    endtask

    // Pulses start, optionally pokes start while busy, and reports edges until done (-1 on timeout).
    task automatic do_run(input bit busy_pulses, output int edges, output logic done_after_start);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_after_start = done;
        edges = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            start = busy_pulses && (n == 5 || n == 34);
            if (done) begin
                edges = n;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b want 0", done); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL idle_done: got %b want 0", done); end
        $display("test_reset: done=%b", done);
    endtask

    task automatic test_directed(input string name, input logic [7:0] b, input logic [7:0] p,
                                 input logic [7:0] x_ctb, input logic [7:0] x_cto, input logic [7:0] x_cts);
        int   edges;
        logic das;
        fill(b, p);
        do_run(1'b0, edges, das);
        n_checks++;
        if (edges !== 36) begin n_fails++; $display("FAIL %s_latency: got %0d want 36", name, edges); end
        n_checks++;
        if (dut.dm1.core[33] !== x_ctb) begin n_fails++; $display("FAIL %s_ctb: got %0d want %0d", name, dut.dm1.core[33], x_ctb); end
        n_checks++;
        if (dut.dm1.core[34] !== x_cto) begin n_fails++; $display("FAIL %s_cto: got %0d want %0d", name, dut.dm1.core[34], x_cto); end
        n_checks++;
        if (dut.dm1.core[35] !== x_cts) begin n_fails++; $display("FAIL %s_cts: got %0d want %0d", name, dut.dm1.core[35], x_cts); end
        $display("test_%s: edges=%0d ctb=%0d cto=%0d cts=%0d", name, edges,
                 dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
    endtask

    task automatic test_random();
        int         edges;
        logic       das;
        logic [7:0] e_ctb, e_cto, e_cts;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
            patbyte = {5'($urandom), 3'($urandom_range(1, 7))};
            // Bias some runs toward dense hits by seeding the pattern from the message.
            if (t % 3 == 0) patbyte[7:3] = msg[t][6:2];
            load_mem();
            ref_model(e_ctb, e_cto, e_cts);
            do_run(1'b0, edges, das);
            n_checks++;
            if (edges !== 36) begin n_fails++; $display("FAIL rand%0d_latency: got %0d want 36", t, edges); end
            n_checks++;
            if (dut.dm1.core[33] !== e_ctb) begin n_fails++; $display("FAIL rand%0d_ctb: got %0d want %0d", t, dut.dm1.core[33], e_ctb); end
            n_checks++;
            if (dut.dm1.core[34] !== e_cto) begin n_fails++; $display("FAIL rand%0d_cto: got %0d want %0d", t, dut.dm1.core[34], e_cto); end
            n_checks++;
            if (dut.dm1.core[35] !== e_cts) begin n_fails++; $display("FAIL rand%0d_cts: got %0d want %0d", t, dut.dm1.core[35], e_cts); end
            $display("test_random[%0d]: pat=%b ctb=%0d/%0d cto=%0d/%0d cts=%0d/%0d", t, patbyte[7:3],
                     dut.dm1.core[33], e_ctb, dut.dm1.core[34], e_cto, dut.dm1.core[35], e_cts);
        end
    endtask

    task automatic test_reset_mid_scan();
        int   edges;
        logic das;
        fill(8'h00, 8'h00);
        dut.dm1.core[33] = 8'hAA;
        dut.dm1.core[34] = 8'hAA;
        dut.dm1.core[35] = 8'hAA;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL midreset_done: got %b want 0", done); end
        repeat (40) @(negedge clk);
        n_checks++;
        if (dut.dm1.core[33] !== 8'hAA) begin n_fails++; $display("FAIL midreset_r33: got %h want aa", dut.dm1.core[33]); end
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL midreset_hold: got %b want 0", done); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        fill(8'h55, 8'hA8);
        do_run(1'b0, edges, das);
        n_checks++;
        if (das !== 1'b0) begin n_fails++; $display("FAIL midreset_start_done: got %b want 0", das); end
        n_checks++;
        if (edges !== 36) begin n_fails++; $display("FAIL midreset_latency: got %0d want 36", edges); end
        n_checks++;
        if (dut.dm1.core[33] !== 8'd64 || dut.dm1.core[34] !== 8'd32 || dut.dm1.core[35] !== 8'd126) begin
            n_fails++;
            $display("FAIL midreset_results: got %0d,%0d,%0d want 64,32,126",
                     dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
        end
        $display("test_reset_mid_scan: edges=%0d results=%0d,%0d,%0d", edges,
                 dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
    endtask

    task automatic test_back_to_back();
        int   edges;
        logic das;
        n_checks++;
        if (done !== 1'b1) begin n_fails++; $display("FAIL b2b_pre_done: got %b want 1", done); end
        fill(8'hF0, 8'h80);
        do_run(1'b1, edges, das);
        n_checks++;
        if (das !== 1'b0) begin n_fails++; $display("FAIL b2b_done_fall: got %b want 0", das); end
        n_checks++;
        if (edges !== 36) begin n_fails++; $display("FAIL b2b_latency: got %0d want 36", edges); end
        n_checks++;
        if (dut.dm1.core[33] !== 8'd32 || dut.dm1.core[34] !== 8'd32 || dut.dm1.core[35] !== 8'd32) begin
            n_fails++;
            $display("FAIL b2b_results: got %0d,%0d,%0d want 32,32,32",
                     dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fails++; $display("FAIL b2b_done_hold: got %b want 1", done); end
        $display("test_back_to_back: edges=%0d results=%0d,%0d,%0d", edges,
                 dut.dm1.core[33], dut.dm1.core[34], dut.dm1.core[35]);
    endtask

    initial begin
        test_reset();
        test_directed("zeros", 8'h00, 8'h00, 8'd128, 8'd32, 8'd252);
        test_directed("f0",    8'hF0, 8'h80, 8'd32,  8'd32, 8'd32);
        test_directed("55",    8'h55, 8'hA8, 8'd64,  8'd32, 8'd126);
        test_directed("55lsb", 8'h55, 8'hAF, 8'd64,  8'd32, 8'd126);
        test_random();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
